// File: rtl/axis_i2c_slave.sv
// axis_i2c_slave: oversampling I2C target bridging written bytes to m_axis and read bytes from s_axis
module axis_i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         HOLD_CYCLES = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        busy_o,
  output logic        underrun_o
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_scl_s, r_sda_s;
  logic r_scl_p, r_sda_p, r_ack, r_oe_tgt;
  logic [2:0] r_cnt;
  logic [7:0] r_shift, r_addr, r_tx;
  logic [HW-1:0] r_hold;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_match;
  logic w_oe_set, w_oe_val, w_ack_set, w_rd_load, w_wr_load;
  logic [7:0] w_tx_new;
  assign w_scl    = r_scl_s[SYNC_STAGES-1];
  assign w_sda    = r_sda_s[SYNC_STAGES-1];
  assign w_rise   = w_scl & ~r_scl_p;
  assign w_fall   = ~w_scl & r_scl_p;
  assign w_start  = w_scl & r_scl_p & r_sda_p & ~w_sda;
  assign w_stop   = w_scl & r_scl_p & ~r_sda_p & w_sda;
  assign w_match  = r_shift[7:1] == SLAVE_ADDR;
  assign w_tx_new = s_axis_tvalid ? s_axis_tdata : 8'hFF;
  // Bits are sampled on SCL rise; every ACK state sees two SCL falls: the first
  // starts the ACK slot (r_ack=0), the second ends it and moves on (r_ack=1).
  always_comb begin
    w_state_nxt = r_state;
    w_oe_set    = 1'b0;
    w_oe_val    = 1'b0;
    w_ack_set   = 1'b0;
    w_rd_load   = 1'b0;
    w_wr_load   = 1'b0;
    if (w_stop) w_state_nxt = IDLE;
    else if (w_start) w_state_nxt = ADDR;
    else if (w_rise) begin
      if (r_cnt == 3'd0)
        w_state_nxt = r_state == ADDR ? ADDR_ACK : r_state == WR_DATA ? WR_ACK : r_state == RD_DATA ? RD_ACK : r_state;
      if (r_state == RD_ACK) begin
        w_ack_set   = ~w_sda;
        w_state_nxt = w_sda ? WAIT_STOP : RD_ACK;
      end
    end else if (w_fall) begin
      case (r_state)
        ADDR_ACK: begin
          w_oe_set    = 1'b1;
          w_oe_val    = ~r_ack & w_match;
          w_ack_set   = ~r_ack;
          w_rd_load   = r_ack & r_addr[0];
          w_state_nxt = r_ack ? (r_addr[0] ? RD_DATA : WR_DATA) : (w_match ? ADDR_ACK : WAIT_STOP);
        end
        WR_ACK: begin
          w_oe_set    = 1'b1;
          w_wr_load   = ~r_ack & ~m_axis_tvalid;
          w_oe_val    = w_wr_load;
          w_ack_set   = ~r_ack;
          w_state_nxt = r_ack ? WR_DATA : WR_ACK;
        end
        RD_DATA: begin
          w_oe_set = 1'b1;
          w_oe_val = ~r_tx[r_cnt];
        end
        RD_ACK: begin
          w_oe_set    = 1'b1;
          w_rd_load   = r_ack;
          w_state_nxt = r_ack ? RD_DATA : RD_ACK;
        end
        default: ;
      endcase
      if (w_rd_load) w_oe_val = ~w_tx_new[7];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_s       <= '1;
      r_sda_s       <= '1;
      r_scl_p       <= 1'b1;
      r_sda_p       <= 1'b1;
      r_ack         <= 1'b0;
      r_cnt         <= 3'd7;
      r_shift       <= '0;
      r_addr        <= '0;
      r_tx          <= '0;
      r_oe_tgt      <= 1'b0;
      r_hold        <= '0;
      sda_oe_o      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
      busy_o        <= 1'b0;
      underrun_o    <= 1'b0;
    end else begin
      r_scl_s <= {r_scl_s[SYNC_STAGES-2:0], scl_i};
      r_sda_s <= {r_sda_s[SYNC_STAGES-2:0], sda_i};
      r_scl_p <= w_scl;
      r_sda_p <= w_sda;
      r_ack   <= (w_start || w_state_nxt != r_state) ? 1'b0 : r_ack | w_ack_set;
      // the 3-bit counter wraps 0->7, so it is ready for the next byte after each ACK slot
      if (w_start) r_cnt <= 3'd7;
      else if (w_rise && (r_state == ADDR || r_state == WR_DATA || r_state == RD_DATA)) r_cnt <= r_cnt - 3'd1;
      if (w_rise && (r_state == ADDR || r_state == WR_DATA)) r_shift <= {r_shift[6:0], w_sda};
      if (w_fall && r_state == ADDR_ACK && !r_ack) r_addr <= r_shift;
      if (w_rd_load) r_tx <= w_tx_new;
      s_axis_tready <= w_rd_load & s_axis_tvalid;
      underrun_o    <= w_rd_load & ~s_axis_tvalid;
      if (w_wr_load) begin
        m_axis_tdata  <= {r_addr, r_shift};
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tdata  <= '0;
        m_axis_tvalid <= 1'b0;
      end
      busy_o <= w_state_nxt != IDLE;
      if (w_start || w_stop) begin
        r_oe_tgt <= 1'b0;
        r_hold   <= '0;
        sda_oe_o <= 1'b0;
      end else begin
        if (w_oe_set) begin
          r_oe_tgt <= w_oe_val;
          r_hold   <= HW'(HOLD_CYCLES);
        end else if (r_hold != '0) r_hold <= r_hold - HW'(1);
        if (r_hold == HW'(1)) sda_oe_o <= r_oe_tgt;
      end
    end
  end
endmodule

// File: tb/tb_axis_i2c_slave.sv
// tb_axis_i2c_slave: bit-banged I2C master with queue scoreboard for axis_i2c_slave
module tb_axis_i2c_slave;
  localparam int HP = 24;
  logic clk = 1'b0, rst = 1'b1;
  logic m_scl = 1'b1, m_sda = 1'b1, sda_bus;
  logic sda_oe, m_tvalid, s_tready, busy, underrun;
  logic m_tready = 1'b1, s_tvalid = 1'b0;
  logic [15:0] m_tdata;
  logic [7:0] s_tdata = 8'h00;
  int checks = 0, failures = 0;
  int n_taken = 0, n_under = 0, exp_taken = 0, exp_under = 0;
  bit oe_seen = 0, pend = 0;
  logic [15:0] exp_m[$];
  int exp_bus[$], obs_bus[$];
  logic [7:0] rd_src[$], mdl_rd[$], wr_data[$];
  assign sda_bus = m_sda & ~sda_oe;
  axis_i2c_slave dut (
    .clk_i(clk), .rst_i(rst), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe_o(sda_oe),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .busy_o(busy), .underrun_o(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  // monitor: pops expectations whenever the DUT presents a beat or the bus yields a bit-level result
  initial forever begin
    @(negedge clk);
    #1;
    if (sda_oe) oe_seen = 1;
    if (underrun) n_under++;
    if (s_tready) begin
      n_taken++;
      if (rd_src.size() != 0) void'(rd_src.pop_front());
    end
    s_tvalid = rd_src.size() != 0;
    s_tdata  = s_tvalid ? rd_src[0] : 8'h00;
    if (m_tvalid && m_tready) begin
      if (exp_m.size() == 0) chk("m_axis_extra_beat", int'(m_tdata), -1);
      else chk("m_axis_tdata", int'(m_tdata), int'(exp_m.pop_front()));
    end
    while (obs_bus.size() != 0) begin
      if (exp_bus.size() == 0) chk("bus_extra", obs_bus.pop_front(), -1);
      else chk("bus_ack_or_rdbyte", obs_bus.pop_front(), exp_bus.pop_front());
    end
  end
  initial begin
    #900000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  task automatic bit_x(input logic b, output logic r);
    m_sda = b; wclk(HP/2);
    m_scl = 1'b1; wclk(HP/4);
    r = sda_bus; wclk(HP/4);
    m_scl = 1'b0; wclk(HP/2);
  endtask
  task automatic m_start();
    m_sda = 1'b1; wclk(HP/2);
    m_scl = 1'b1; wclk(HP/2);
    m_sda = 1'b0; wclk(HP/2);
    m_scl = 1'b0; wclk(HP/2);
  endtask
  task automatic m_stop();
    m_sda = 1'b0; wclk(HP/2);
    m_scl = 1'b1; wclk(HP/2);
    m_sda = 1'b1; wclk(HP);
  endtask
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, r);
    ack = ~r;
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(nack, r);
  endtask
  // reference: target answers 0x50 only; a write byte is accepted iff no word is waiting;
  // read bytes come from the source queue in order, 0xFF with an underrun when it is empty
  task automatic txn(input logic [7:0] ab, input int n, input bit bp, input bit stop);
    logic a, match, acc;
    logic [7:0] d;
    match = ab[7:1] == 7'h50;
    m_tready = !bp;
    m_start();
    chk("busy_after_start", int'(busy), 1);
    exp_bus.push_back(256 | int'(match));
    write_byte(ab, a);
    obs_bus.push_back(256 | int'(a));
    for (int k = 0; k < n; k++) begin
      if (match && ab[0]) begin
        if (mdl_rd.size() != 0) begin
          exp_bus.push_back(512 | int'(mdl_rd.pop_front()));
          exp_taken++;
        end else begin
          exp_bus.push_back(512 | 8'hFF);
          exp_under++;
        end
        read_byte(k == n - 1, d);
        obs_bus.push_back(512 | int'(d));
      end else begin
        d = wr_data.size() != 0 ? wr_data.pop_front() : 8'($urandom);
        acc = match && !pend;
        exp_bus.push_back(256 | int'(acc));
        if (acc) begin
          exp_m.push_back({ab, d});
          pend = bp;
        end
        write_byte(d, a);
        obs_bus.push_back(256 | int'(a));
      end
    end
    if (stop) begin
      m_stop();
      chk("busy_after_stop", int'(busy), 0);
    end
  endtask
  task automatic release_bp();
    m_tready = 1'b1;
    pend = 0;
    wclk(4);
  endtask
  initial begin
    logic a, r, stop, bp;
    logic [6:0] ad;
    logic [7:0] ab, v;
    int n, kind;
    wclk(4);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_m_tdata", int'(m_tdata), 0);
    chk("rst_s_tready", int'(s_tready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_underrun", int'(underrun), 0);
    rst = 1'b0;
    wclk(10);
    wr_data.push_back(8'hA5);
    txn(8'hA0, 1, 0, 1);
    oe_seen = 0;
    wr_data.push_back(8'h11);
    txn(8'hA2, 1, 0, 1);
    chk("mismatch_sda_never_pulled", int'(oe_seen), 0);
    rd_src.push_back(8'h3C);
    mdl_rd.push_back(8'h3C);
    txn(8'hA1, 1, 0, 1);
    wr_data.push_back(8'h11);
    wr_data.push_back(8'h22);
    txn(8'hA0, 2, 1, 1);
    wclk(8);
    chk("bp_held_tvalid", int'(m_tvalid), 1);
    chk("bp_held_tdata", int'(m_tdata), 16'hA011);
    release_bp();
    txn(8'hA1, 1, 0, 0);
    wr_data.push_back(8'h5A);
    txn(8'hA0, 1, 0, 1);
    rd_src.push_back(8'h00);
    exp_taken++;
    m_start();
    write_byte(8'hA1, a);
    chk("rst_test_addr_ack", int'(a), 1);
    for (int i = 0; i < 4; i++) begin
      bit_x(1'b1, r);
      chk("rst_test_rd_bit", int'(r), 0);
    end
    wclk(4);
    chk("rst_test_driving_before", int'(sda_oe), 1);
    rst = 1'b1;
    wclk(1);
    rst = 1'b0;
    chk("rst_test_sda_released", int'(sda_oe), 0);
    chk("rst_test_busy", int'(busy), 0);
    oe_seen = 0;
    for (int i = 0; i < 5; i++) bit_x(1'b1, r);
    m_stop();
    chk("rst_test_bits_ignored", int'(oe_seen), 0);
    wr_data.push_back(8'h77);
    txn(8'hA0, 1, 0, 1);
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      if (kind >= 2) begin
        do ad = 7'($urandom); while (ad == 7'h50);
        ab = {ad, 1'($urandom)};
      end else ab = {7'h50, kind == 1};
      n = $urandom_range(1, 3);
      bp = kind == 0 && $urandom_range(0, 3) == 0;
      if (kind == 1)
        for (int k = 0; k < n; k++)
          if ($urandom_range(0, 3) != 0) begin
            v = 8'($urandom);
            rd_src.push_back(v);
            mdl_rd.push_back(v);
          end
      stop = $urandom_range(0, 2) != 0 || t == 19;
      txn(ab, n, bp, stop);
      if (bp) release_bp();
    end
    wclk(100);
    chk("m_axis_all_beats_seen", exp_m.size(), 0);
    chk("bus_all_results_seen", exp_bus.size(), 0);
    chk("s_axis_tready_pulses", n_taken, exp_taken);
    chk("underrun_pulses", n_under, exp_under);
    chk("final_busy", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
